// File: rtl/time_set_controller.sv
// Manual time-setting sequencer for the wall clock: center button walks RUN->HOUR->MIN->SEC,
// up/down emit single-cycle inc/dec pulses to the selected counter with hold-to-repeat.
module time_set_controller #(
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int IDLE_TIMEOUT  = 1000000000
) (
  input  logic       clk,
  input  logic       Nreset,
  input  logic       up_status,
  input  logic       down_status,
  input  logic       center_pulse,
  output logic       up_seg,
  output logic       up_min,
  output logic       up_hour,
  output logic       down_seg,
  output logic       down_min,
  output logic       down_hour,
  output logic [1:0] mode,
  output logic [2:0] field_sel,
  output logic       setting
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int IW   = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_PERIOD - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

  mode_e         mode_q;
  logic [2:0]    field_sel_q;
  logic          setting_q;
  logic          up_seg_q, up_min_q, up_hour_q;
  logic          down_seg_q, down_min_q, down_hour_q;
  logic          up_prev_q, down_prev_q;
  logic          lock_q, lock_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] idle_q, idle_d;

  logic in_set, any_btn, armed, solo_up, solo_dn;
  logic press_up, press_dn, held_up, held_dn, rep_due;
  logic fire_up, fire_dn, idle_now, timeout;
  mode_e mode_d;

  // hold_q counts down to the next pulse while a button is held; it only
  // reaches a "held" state through a clean press, since every other way of
  // getting a button held in a set mode goes through lockout.
  always_comb begin
    in_set   = (mode_q != RUN);
    any_btn  = up_status | down_status;
    solo_up  = up_status & ~down_status;
    solo_dn  = down_status & ~up_status;
    armed    = in_set & ~lock_q & ~center_pulse;
    press_up = armed & solo_up & ~up_prev_q;
    press_dn = armed & solo_dn & ~down_prev_q;
    held_up  = armed & solo_up & up_prev_q;
    held_dn  = armed & solo_dn & down_prev_q;
    rep_due  = (hold_q == '0);
    fire_up  = press_up | (held_up & rep_due);
    fire_dn  = press_dn | (held_dn & rep_due);

    hold_d = '0;
    if (press_up | press_dn)
      hold_d = HOLD_FIRST;
    else if (held_up | held_dn)
      hold_d = rep_due ? HOLD_NEXT : hold_q - 1'b1;

    lock_d = lock_q;
    if (!any_btn)
      lock_d = 1'b0;
    else if ((in_set & up_status & down_status) | center_pulse)
      lock_d = 1'b1;

    idle_now = in_set & ~any_btn & ~center_pulse;
    timeout  = idle_now & (idle_q >= IDLE_LAST);
    idle_d   = '0;
    if (idle_now && !timeout)
      idle_d = idle_q + 1'b1;

    mode_d = mode_q;
    if (center_pulse) begin
      case (mode_q)
        RUN:      mode_d = SET_HOUR;
        SET_HOUR: mode_d = SET_MIN;
        SET_MIN:  mode_d = SET_SEC;
        default:  mode_d = RUN;
      endcase
    end else if (timeout) begin
      mode_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (Nreset) begin
      mode_q      <= RUN;
      field_sel_q <= 3'b000;
      setting_q   <= 1'b0;
      up_seg_q    <= 1'b0;
      up_min_q    <= 1'b0;
      up_hour_q   <= 1'b0;
      down_seg_q  <= 1'b0;
      down_min_q  <= 1'b0;
      down_hour_q <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      lock_q      <= 1'b0;
      hold_q      <= '0;
      idle_q      <= '0;
    end else begin
      mode_q    <= mode_d;
      setting_q <= (mode_d != RUN);
      case (mode_d)
        SET_HOUR: field_sel_q <= 3'b100;
        SET_MIN:  field_sel_q <= 3'b010;
        SET_SEC:  field_sel_q <= 3'b001;
        default:  field_sel_q <= 3'b000;
      endcase
      up_hour_q   <= fire_up & (mode_q == SET_HOUR);
      up_min_q    <= fire_up & (mode_q == SET_MIN);
      up_seg_q    <= fire_up & (mode_q == SET_SEC);
      down_hour_q <= fire_dn & (mode_q == SET_HOUR);
      down_min_q  <= fire_dn & (mode_q == SET_MIN);
      down_seg_q  <= fire_dn & (mode_q == SET_SEC);
      up_prev_q   <= up_status;
      down_prev_q <= down_status;
      lock_q      <= lock_d;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
    end
  end

  assign mode      = mode_q;
  assign field_sel = field_sel_q;
  assign setting   = setting_q;
  assign up_seg    = up_seg_q;
  assign up_min    = up_min_q;
  assign up_hour   = up_hour_q;
  assign down_seg  = down_seg_q;
  assign down_min  = down_min_q;
  assign down_hour = down_hour_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short repeat/timeout parameters.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       Nreset, up_status, down_status, center_pulse;
  logic       up_seg, up_min, up_hour, down_seg, down_min, down_hour;
  logic [1:0] mode;
  logic [2:0] field_sel;
  logic       setting;

  int vecs = 0;
  int miss = 0;

  localparam logic [5:0] P0   = 6'b000000;
  localparam logic [5:0] P_UH = 6'b100000;
  localparam logic [5:0] P_UM = 6'b010000;
  localparam logic [5:0] P_US = 6'b001000;
  localparam logic [5:0] P_DH = 6'b000100;

  time_set_controller #(
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3),
    .IDLE_TIMEOUT (20)
  ) dut (
    .clk         (clk),
    .Nreset      (Nreset),
    .up_status   (up_status),
    .down_status (down_status),
    .center_pulse(center_pulse),
    .up_seg      (up_seg),
    .up_min      (up_min),
    .up_hour     (up_hour),
    .down_seg    (down_seg),
    .down_min    (down_min),
    .down_hour   (down_hour),
    .mode        (mode),
    .field_sel   (field_sel),
    .setting     (setting)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pulse order: {up_hour, up_min, up_seg, down_hour, down_min, down_seg}
  task automatic chk(input string tag, input logic [1:0] em, input logic [2:0] efs,
                     input logic es, input logic [5:0] ep);
    logic [11:0] obs, exp;
    obs = {mode, field_sel, setting, up_hour, up_min, up_seg, down_hour, down_min, down_seg};
    exp = {em, efs, es, ep};
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: mode/fs/set/pulses observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] cyc_mode [4];
    logic [2:0] cyc_fs   [4];
    cyc_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
    cyc_fs   = '{3'b100, 3'b010, 3'b001, 3'b000};

    // reset with an up level and a center pulse present
    Nreset = 1'b1; up_status = 1'b1; down_status = 1'b0; center_pulse = 1'b1;
    step();
    step();
    chk("reset", 2'd0, 3'b000, 1'b0, P0);
    Nreset = 1'b0; center_pulse = 1'b0;
    step();
    chk("post_reset_up_in_run", 2'd0, 3'b000, 1'b0, P0);
    up_status = 1'b0;
    step();
    chk("run_idle", 2'd0, 3'b000, 1'b0, P0);

    // mode cycling, center pulses 5 cycles apart
    for (int i = 0; i < 4; i++) begin
      center_pulse = 1'b1;
      step();
      center_pulse = 1'b0;
      chk($sformatf("cycle_%0d", i), cyc_mode[i], cyc_fs[i], (i != 3), P0);
      repeat (4) step();
    end

    // press and hold up in SET_MIN for 20 cycles
    center_pulse = 1'b1;
    step(); chk("to_hour", 2'd1, 3'b100, 1'b1, P0);
    step(); chk("to_min", 2'd2, 3'b010, 1'b1, P0);
    center_pulse = 1'b0;
    up_status = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("hold_min_%0d", i), 2'd2, 3'b010, 1'b1,
          (i == 0 || i == 8 || i == 11 || i == 14 || i == 17) ? P_UM : P0);
    end
    up_status = 1'b0;
    step(); chk("hold_min_release", 2'd2, 3'b010, 1'b1, P0);

    // conflict in SET_HOUR
    center_pulse = 1'b1;
    step(); chk("c_to_sec", 2'd3, 3'b001, 1'b1, P0);
    step(); chk("c_to_run", 2'd0, 3'b000, 1'b0, P0);
    step(); chk("c_to_hour", 2'd1, 3'b100, 1'b1, P0);
    center_pulse = 1'b0;
    down_status = 1'b1;
    step(); chk("down_press", 2'd1, 3'b100, 1'b1, P_DH);
    step(); chk("down_held", 2'd1, 3'b100, 1'b1, P0);
    up_status = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); chk($sformatf("both_%0d", i), 2'd1, 3'b100, 1'b1, P0);
    end
    up_status = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); chk($sformatf("down_locked_%0d", i), 2'd1, 3'b100, 1'b1, P0);
    end
    down_status = 1'b0;
    step(); chk("unlock", 2'd1, 3'b100, 1'b1, P0);
    down_status = 1'b1;
    step(); chk("down_repress", 2'd1, 3'b100, 1'b1, P_DH);
    down_status = 1'b0;
    step(); chk("down_rel", 2'd1, 3'b100, 1'b1, P0);

    // center while a button is held
    center_pulse = 1'b1;
    step(); chk("h_to_min", 2'd2, 3'b010, 1'b1, P0);
    step(); chk("h_to_sec", 2'd3, 3'b001, 1'b1, P0);
    center_pulse = 1'b0;
    up_status = 1'b1;
    step(); chk("sec_press", 2'd3, 3'b001, 1'b1, P_US);
    step(); chk("sec_held", 2'd3, 3'b001, 1'b1, P0);
    center_pulse = 1'b1;
    step(); chk("held_center_run", 2'd0, 3'b000, 1'b0, P0);
    step(); chk("held_center_hour", 2'd1, 3'b100, 1'b1, P0);
    center_pulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(); chk($sformatf("held_locked_%0d", i), 2'd1, 3'b100, 1'b1, P0);
    end
    up_status = 1'b0;
    step(); chk("held_release", 2'd1, 3'b100, 1'b1, P0);
    up_status = 1'b1;
    step(); chk("up_repress", 2'd1, 3'b100, 1'b1, P_UH);
    up_status = 1'b0;
    step(); chk("up_rel", 2'd1, 3'b100, 1'b1, P0);

    // idle timeout: cycle round to SET_HOUR, then leave idle
    center_pulse = 1'b1;
    step(); chk("t_min", 2'd2, 3'b010, 1'b1, P0);
    step(); chk("t_sec", 2'd3, 3'b001, 1'b1, P0);
    step(); chk("t_run", 2'd0, 3'b000, 1'b0, P0);
    step(); chk("t_hour", 2'd1, 3'b100, 1'b1, P0);
    center_pulse = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 19) chk("timeout_m1", 2'd1, 3'b100, 1'b1, P0);
      if (j == 20) chk("timeout", 2'd0, 3'b000, 1'b0, P0);
    end

    // timeout restarted by a down press at cycle 15
    center_pulse = 1'b1;
    step(); chk("t2_hour", 2'd1, 3'b100, 1'b1, P0);
    center_pulse = 1'b0;
    repeat (14) step();
    down_status = 1'b1;
    step(); chk("t2_press15", 2'd1, 3'b100, 1'b1, P_DH);
    down_status = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 5)  chk("t2_old_deadline", 2'd1, 3'b100, 1'b1, P0);
      if (n == 19) chk("t2_timeout_m1", 2'd1, 3'b100, 1'b1, P0);
      if (n == 20) chk("t2_timeout", 2'd0, 3'b000, 1'b0, P0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences manual time setting for the wall clock.
- Turns debounced up/down/center button signals into a mode state machine (RUN, SET_HOUR, SET_MIN, SET_SEC).
- Emits single-cycle increment/decrement pulses to the seconds, minutes and hours counter modules, with hold-to-repeat.
- Sits between the three PB_Debouncer_FSM instances and the seg/min/hour counters, replacing timed_FSM; also gives the display path a field-select for blinking.

Parameters:
- REPEAT_DELAY, 50000000: cycles a button must be held after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat pulses.
- IDLE_TIMEOUT, 1000000000: consecutive idle cycles in a set mode before returning to RUN.

Ports:
- clk  in  1  system clock
- Nreset  in  1  synchronous, active-high reset
- up_status  in  1  debounced up level
- down_status  in  1  debounced down level
- center_pulse  in  1  debounced center press, 1-cycle pulse
- up_seg  out  1  increment-seconds pulse
- up_min  out  1  increment-minutes pulse
- up_hour  out  1  increment-hours pulse
- down_seg  out  1  decrement-seconds pulse
- down_min  out  1  decrement-minutes pulse
- down_hour  out  1  decrement-hours pulse
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
- field_sel  out  3  one-hot {hour,min,sec}; 000 in RUN
- setting  out  1  high when mode != RUN

Behaviour:
- One clock domain. Every output is registered.
- Reset (Nreset=1 sampled at a clk edge): mode=RUN, all pulses 0, field_sel=000, setting=0, lockout=0, all counters 0, previous-sample registers 0. Reset mid-hold or mid-set discards all state.
- Counters (hold, idle) are sized to their largest parameter and saturate; they never wrap.
- Mode FSM: center_pulse=1 at an edge advances the mode RUN->SET_HOUR->SET_MIN->SET_SEC->RUN. mode, field_sel and setting update at that same edge.
- In RUN: up/down are ignored, all pulses stay 0, the idle counter is held at 0.
- Press: an edge where the button is sampled 1 and was 0 the previous cycle, in a set mode, not locked out, other button 0. Within that edge the matching pulse for the current field is asserted for exactly one cycle: up_* for up, down_* for down; hour/min/sec per mode. Latency is 1 cycle from sampling.
- Repeat: while the same button stays 1, further pulses occur at press edge + REPEAT_DELAY, then every REPEAT_PERIOD after. Releasing the button clears the hold counter.
- Both buttons 1 in the same cycle: no pulse, hold counter cleared, lockout set.
- center_pulse at an edge with a button held: mode advances, no pulse, hold counter cleared, lockout set.
- center_pulse and a press edge together: the center_pulse wins and no pulse is generated.
- Lockout: suppresses all pulses and clears only at an edge where both buttons sample 0.
- At most one of the six pulse outputs is high in any cycle.
- Idle timeout: in a set mode, the idle counter increments each cycle with up_status=0, down_status=0, center_pulse=0, and clears otherwise. When it reaches IDLE_TIMEOUT the mode goes to RUN at that edge and the counter clears.
- A timeout during lockout is not possible, because buttons are released by definition of idle.

Test Plan (REPEAT_DELAY=8, REPEAT_PERIOD=3, IDLE_TIMEOUT=20):
- Reset: assert Nreset with up_status=1 and a center pulse -> mode=0, field_sel=000, all pulses 0 during reset and on the first cycle after release.
- Mode cycling: 4 center pulses 5 cycles apart -> mode 1,2,3,0. field_sel 100,010,001,000. setting 1,1,1,0.
- Single press and hold in SET_MIN: raise up_status at edge k and hold 20 cycles -> up_min pulses at k, k+8, k+11, k+14, k+17 only; other outputs 0.
- Conflict: in SET_HOUR, hold down_status, then raise up_status -> pulses stop. Release up only -> still none. Release both, press down -> down_hour pulses again.
- Center while held: in SET_SEC, hold up_status and pulse center -> mode=0, no pulse. Go to SET_HOUR with up still held -> no up_hour until release and re-press.
- Timeout: enter SET_HOUR and leave inputs idle -> mode returns to 0 exactly 20 cycles later. A down press at cycle 15 restarts the count and emits one down_hour pulse.
